// File: rtl/sorted_stream_out.sv
// Holds one sorted frame from the upstream sorter and replays it as a valid/ready stream,
// checking on the way out that the frame really is non-decreasing.
`ifndef NUM_TESTS_DEEP
`define NUM_TESTS_DEEP 8
`endif

module sorted_stream_out #(
    parameter int DEPTH = `NUM_TESTS_DEEP,
    parameter int WIDTH = 32,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sort_done,
    input  logic [WIDTH-1:0] sort_data [0:DEPTH-1],
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IW-1:0]    m_index,
    output logic             m_last,
    output logic             busy,
    output logic             frame_done,
    output logic             order_err,
    output logic [IW:0]      err_count,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW:0]   ERR_MAX  = (IW + 1)'(DEPTH - 1);

    function automatic logic [IW:0] sat_inc(input logic [IW:0] v);
        return (v >= ERR_MAX) ? ERR_MAX : v + (IW + 1)'(1);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_buf [0:DEPTH-1];
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_prev;
    logic             r_order_err;
    logic [IW:0]      r_err_cnt;
    logic             r_overrun;

    logic             w_capture;
    logic             w_xfer;
    logic             w_at_last;
    logic             w_viol;
    logic [WIDTH-1:0] w_cur;

    assign w_capture = (r_state == IDLE) && sort_done;
    assign w_xfer    = (r_state == STREAM) && m_ready;
    assign w_cur     = r_buf[r_idx];
    assign w_at_last = (r_idx == LAST_IDX);
    // Unsigned compare against the previously accepted element; equal values are in order.
    assign w_viol    = w_xfer && (r_idx != '0) && (w_cur < r_prev);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sort_done) w_next = STREAM;
            STREAM:  if (w_xfer && w_at_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_order_err <= 1'b0;
            r_err_cnt   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_idx       <= '0;
                r_order_err <= 1'b0;
                r_err_cnt   <= '0;
            end else begin
                if (w_xfer && !w_at_last) r_idx <= r_idx + IW'(1);
                if (w_viol) begin
                    r_order_err <= 1'b1;
                    r_err_cnt   <= sat_inc(r_err_cnt);
                end
            end
            if (sort_done && (r_state != IDLE)) r_overrun <= 1'b1;
        end
    end

    // Frame storage and the running previous value carry no reset; both are
    // always written before they are read.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= sort_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) r_prev <= w_cur;
    end

    assign m_valid    = (r_state == STREAM);
    assign m_data     = m_valid ? w_cur : '0;
    assign m_index    = r_idx;
    assign m_last     = m_valid && w_at_last;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);
    assign order_err  = r_order_err;
    assign err_count  = r_err_cnt;
    assign overrun    = r_overrun;

endmodule

// File: doc/sorted_stream_out.md
SORTED_STREAM_OUT -- requirements
Module: sorted_stream_out

Interface
REQ-001 The block SHALL have parameter DEPTH, default `NUM_TESTS_DEEP (from test_params.svh), meaning the number of array elements per frame (DEPTH >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the element width in bits.
REQ-003 Port clk  input  1  rising-edge clock for all logic.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port sort_done  input  1  one-cycle pulse from the upstream sorter: frame ready.
REQ-006 Port sort_data  input  WIDTH x [0:DEPTH-1] unpacked array  sorted frame, valid in the sort_done cycle.
REQ-007 Port m_valid  output  1  output stream element valid.
REQ-008 Port m_ready  input  1  downstream accepts the element.
REQ-009 Port m_data  output  WIDTH  current element.
REQ-010 Port m_index  output  IW = $clog2(DEPTH)  index of the current element.
REQ-011 Port m_last  output  1  current element is index DEPTH-1.
REQ-012 Port busy  output  1  a frame is held or being streamed (state != IDLE).
REQ-013 Port frame_done  output  1  one-cycle pulse after the last element is accepted.
REQ-014 Port order_err  output  1  sticky flag: current/last frame was not non-decreasing.
REQ-015 Port err_count  output  IW+1  count of order violations in the current/last frame.
REQ-016 Port overrun  output  1  sticky flag: sort_done arrived while busy; cleared only by reset.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-018 In IDLE with sort_done=1, the block SHALL copy sort_data into an internal DEPTH x WIDTH buffer, set index=0, clear order_err and err_count, and enter STREAM.
REQ-019 With sort_done at edge T, m_valid SHALL be 1 from T+1, with m_data=buf[0] and m_index=0.
REQ-020 In STREAM, m_valid SHALL be 1, m_data SHALL equal buf[index], and m_index SHALL equal index.
REQ-021 m_data, m_index and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 A transfer SHALL occur on a rising edge where m_valid and m_ready are both 1; no other edge advances the index.
REQ-023 On each transfer with index>0, if buf[index] < prev (unsigned), err_count SHALL increment by 1 and order_err SHALL set; prev SHALL load buf[index] on every transfer.
REQ-024 A transfer with index=DEPTH-1 (m_last=1) SHALL move the FSM to DONE; any other transfer SHALL increment index.
REQ-025 In DONE, frame_done SHALL be 1 for exactly one cycle, m_valid SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-026 With m_ready held at 1, the block SHALL sustain one element per cycle: elements at T+1..T+DEPTH, frame_done at T+DEPTH+1, and busy=0 from T+DEPTH+2.
REQ-027 sort_done in STREAM or DONE SHALL NOT alter the buffer, index or stream, and SHALL set overrun.
REQ-028 The buffer SHALL be written only on capture; sort_data SHALL be ignored in all other cycles.
REQ-029 order_err and err_count SHALL hold their final values after frame_done until the next capture.
REQ-030 The compare SHALL be unsigned at full WIDTH, and equal adjacent values SHALL NOT count as a violation.
REQ-031 err_count SHALL NOT wrap; its maximum is DEPTH-1, which fits in IW+1 bits.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, m_valid=0, m_last=0, busy=0, frame_done=0, order_err=0, err_count=0, overrun=0, m_index=0 and m_data=0, regardless of the clock.
REQ-033 Reset asserted mid-STREAM SHALL abandon the frame with no frame_done, and the first sort_done after release SHALL start a fresh frame at index 0.
REQ-034 Buffer contents SHALL need no reset.

Verification
REQ-035 DEPTH=4, sort_data={1,2,2,9}, sort_done at T, m_ready=1 -> m_data 1,2,2,9 at T+1..T+4, m_last only at T+4, frame_done at T+5, order_err=0, err_count=0.
REQ-036 Same frame with m_ready toggling 1,0,0,1,... -> each element is held stable while stalled, all 4 are delivered in order, and frame_done follows the 4th transfer.
REQ-037 sort_data={5,3,4,1} -> order_err=1 and err_count=2 after frame_done, both held until the next capture, then cleared.
REQ-038 sort_done pulsed again at T+2 with different data -> stream unchanged (1,2,2,9) and overrun=1 until reset.
REQ-039 rst_n low at T+2 mid-stream -> all outputs at reset values asynchronously and no frame_done; a new sort_done then streams from index 0.
REQ-040 sort_data={FFFFFFFF,0,...}, full 32-bit range -> unsigned compare flags 1 violation at index 1.
